// File: rtl/vin_pkg.sv
// Shared types and constants for the vin period-measurement scheduler.
package vin_pkg;

    localparam int CNT_W  = 32;
    localparam int CHAN_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        STORE
    } vin_state_t;

    function automatic logic [CHAN_W-1:0] next_chan(input logic [CHAN_W-1:0] cur, input int channels);
        return (cur == CHAN_W'(channels - 1)) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/vin_edge_sync.sv
// Three-flop synchroniser for one raw vin pin with rising-edge detect on the synchronised copy.
module vin_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic [2:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else begin
            r_sig <= {r_sig[1:0], i_sig};
        end
    end

    assign o_rise = (r_sig[2:1] == 2'b01);

endmodule

// File: rtl/vin_frequency_scheduler.sv
// Round-robin period measurement: one shared counter walks the channels, arming on a rising
// edge, counting clk cycles to the next rising edge and storing the result per channel.
module vin_frequency_scheduler
    import vin_pkg::*;
#(
    parameter int          CHANNELS  = 4,
    parameter int unsigned RESET_CNT = 25000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       SIGNAL,
    output logic [CNT_W*CHANNELS-1:0] period,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       timeout,
    output logic                      update,
    output logic [CHAN_W-1:0]         chan
);

    localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(RESET_CNT);

    logic [CHANNELS-1:0] w_rise;

    vin_state_t        r_state;
    vin_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [CNT_W-1:0]  r_result;
    logic [CNT_W-1:0]  w_result_nxt;
    logic [CHAN_W-1:0] r_chan;
    logic [CHAN_W-1:0] w_chan_nxt;
    logic              w_rise_sel;
    logic              w_tmo;
    logic              w_store;

    logic [CHANNELS-1:0][CNT_W-1:0] r_period;
    logic [CHANNELS-1:0]            r_valid;
    logic [CHANNELS-1:0]            r_timeout;
    logic                           r_update;

    // Every pin is synchronised continuously, so switching channels needs no settle time.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        vin_edge_sync u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_sig  (SIGNAL[g]),
            .o_rise (w_rise[g])
        );
    end

    always_comb begin
        w_rise_sel = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_chan == CHAN_W'(i)) begin
                w_rise_sel = w_rise[i];
            end
        end
    end

    // Counter saturates at the timeout value so it can never wrap.
    assign w_tmo     = (r_cnt == LP_TMO);
    assign w_cnt_inc = w_tmo ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_chan   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_chan   <= w_chan_nxt;
        end
    end

    // A rise on the selected channel takes priority over a coincident timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_chan_nxt   = r_chan;
        w_store      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_rise_sel) begin
                    w_state_nxt = MEAS;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (w_tmo) begin
                    w_state_nxt  = STORE;
                    w_result_nxt = '0;
                end
            end
            MEAS: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_rise_sel) begin
                    w_state_nxt  = STORE;
                    w_result_nxt = r_cnt;
                end else if (w_tmo) begin
                    w_state_nxt  = STORE;
                    w_result_nxt = '0;
                end
            end
            STORE: begin
                w_store     = 1'b1;
                w_cnt_nxt   = '0;
                w_chan_nxt  = next_chan(r_chan, CHANNELS);
                w_state_nxt = enable ? ARM : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Result file: entries hold until the channel is measured again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period  <= '0;
            r_valid   <= '0;
            r_timeout <= '0;
            r_update  <= 1'b0;
        end else begin
            r_update <= w_store;
            if (w_store) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (r_chan == CHAN_W'(i)) begin
                        r_period[i]  <= r_result;
                        r_valid[i]   <= 1'b1;
                        r_timeout[i] <= (r_result == '0);
                    end
                end
            end
        end
    end

    assign period  = r_period;
    assign valid   = r_valid;
    assign timeout = r_timeout;
    assign update  = r_update;
    assign chan    = r_chan;

endmodule

// File: tb/tb_vin_frequency_scheduler.sv
// Directed bench: expected stores are queued as stimulus is applied and checked on each update pulse.
module tb_vin_frequency_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_a;
    logic       en_b;
    logic [7:0] s = '0;
    int         p [8] = '{default: 0};
    int         c [8] = '{default: 0};

    logic [127:0] per_a, per_b;
    logic [3:0]   val_a, val_b, to_a, to_b, chan_a, chan_b;
    logic         upd_a, upd_b;

    bit           sel = 1'b0;
    logic [127:0] m_period;
    logic [3:0]   m_valid, m_timeout, m_chan;
    logic         m_upd;

    assign m_period  = sel ? per_b  : per_a;
    assign m_valid   = sel ? val_b  : val_a;
    assign m_timeout = sel ? to_b   : to_a;
    assign m_chan    = sel ? chan_b : chan_a;
    assign m_upd     = sel ? upd_b  : upd_a;

    typedef struct {
        int          ch;
        logic [31:0] per;
        logic        to;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   upd_cnt_a = 0;
    int   upd_snap;

    vin_frequency_scheduler #(.CHANNELS(4), .RESET_CNT(1000)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (en_a),
        .SIGNAL  (s[3:0]),
        .period  (per_a),
        .valid   (val_a),
        .timeout (to_a),
        .update  (upd_a),
        .chan    (chan_a)
    );

    vin_frequency_scheduler #(.CHANNELS(4), .RESET_CNT(5000)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (en_b),
        .SIGNAL  (s[7:4]),
        .period  (per_b),
        .valid   (val_b),
        .timeout (to_b),
        .update  (upd_b),
        .chan    (chan_b)
    );

    // Square-wave sources: lane i rises every p[i] clk cycles; p[i]==0 holds it low.
    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (p[i] == 0) begin
                c[i] <= 0;
                s[i] <= 1'b0;
            end else begin
                c[i] <= (c[i] >= p[i] - 1) ? 0 : c[i] + 1;
                s[i] <= (c[i] < p[i] / 2);
            end
        end
        if (upd_a) upd_cnt_a <= upd_cnt_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int per, input logic to);
        exp_t e;
        e.ch  = ch;
        e.per = 32'(per);
        e.to  = to;
        sb.push_back(e);
    endtask

    task automatic check_next(input string tag);
        exp_t e;
        bit   got;
        int   budget;
        budget = sel ? 12000 : 3000;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (m_upd === 1'b1) got = 1'b1;
        end
        chk({tag, "_update_seen"}, 32'(got), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_period"},  m_period[e.ch*32 +: 32], e.per);
            chk({tag, "_timeout"}, 32'(m_timeout[e.ch]), 32'(e.to));
            chk({tag, "_valid"},   32'(m_valid[e.ch]), 32'd1);
            chk({tag, "_chan"},    32'(m_chan), 32'((e.ch + 1) % 4));
            @(negedge clk);
            chk({tag, "_update_pulse"}, 32'(m_upd), 32'd0);
        end
    endtask

    initial begin
        // 1: reset and idle with enable low
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_period",  per_a[31:0] | per_a[63:32] | per_a[95:64] | per_a[127:96], 32'd0);
        chk("idle_valid",   32'(val_a), 32'd0);
        chk("idle_timeout", 32'(to_a), 32'd0);
        chk("idle_chan",    32'(chan_a), 32'd0);
        chk("idle_updates", 32'(upd_cnt_a), 32'd0);

        // 2: only ch0 toggles, the others time out
        p[0] = 100;
        push(0, 100, 1'b0);
        push(1, 0, 1'b1);
        push(2, 0, 1'b1);
        push(3, 0, 1'b1);
        en_a = 1'b1;
        check_next("t2_ch0");
        chk("t2_valid_after_ch0", 32'(val_a), 32'b0001);
        check_next("t2_ch1");
        check_next("t2_ch2");
        check_next("t2_ch3");
        chk("t2_timeout", 32'(to_a), 32'b1110);
        chk("t2_valid",   32'(val_a), 32'b1111);
        chk("t2_updates", 32'(upd_cnt_a), 32'd4);
        en_a = 1'b0;

        // 3: four distinct periods on the second instance, two rounds
        sel  = 1'b1;
        p[4] = 100;
        p[5] = 37;
        p[6] = 2;
        p[7] = 1000;
        for (int r = 0; r < 2; r++) begin
            push(0, 100, 1'b0);
            push(1, 37, 1'b0);
            push(2, 2, 1'b0);
            push(3, 1000, 1'b0);
        end
        en_b = 1'b1;
        for (int k = 0; k < 8; k++) check_next($sformatf("t3_store%0d", k));
        chk("t3_timeout", 32'(to_b), 32'd0);
        chk("t3_valid",   32'(val_b), 32'b1111);
        en_b = 1'b0;
        sel  = 1'b0;

        // 4: ch2 slower than the timeout, then speeds up
        p[2] = 2000;
        push(1, 0, 1'b1);
        push(2, 0, 1'b1);
        en_a = 1'b1;
        check_next("t4_ch1");
        check_next("t4_ch2_slow");
        chk("t4_timeout2", 32'(to_a[2]), 32'd1);
        p[2] = 500;
        push(3, 0, 1'b1);
        push(0, 100, 1'b0);
        check_next("t4_ch3");
        check_next("t4_ch0");

        // 5: drop enable while ch1 is mid-measurement
        p[1] = 300;
        push(1, 300, 1'b0);
        repeat (50) @(negedge clk);
        en_a = 1'b0;
        check_next("t5_ch1");
        repeat (20) @(negedge clk);
        chk("t5_parked_chan", 32'(chan_a), 32'd2);
        upd_snap = upd_cnt_a;
        repeat (1500) @(negedge clk);
        chk("t5_no_update_idle", 32'(upd_cnt_a), 32'(upd_snap));
        chk("t5_still_chan2",    32'(chan_a), 32'd2);
        push(2, 500, 1'b0);
        en_a = 1'b1;
        check_next("t5_ch2_resume");
        chk("t5_timeout2_clear", 32'(to_a[2]), 32'd0);

        // 6: reset mid-measurement, then restart at ch0
        p[3] = 400;
        p[0] = 0;
        repeat (50) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_period", per_a[31:0] | per_a[63:32] | per_a[95:64] | per_a[127:96], 32'd0);
        chk("t6_valid",   32'(val_a), 32'd0);
        chk("t6_timeout", 32'(to_a), 32'd0);
        chk("t6_update",  32'(upd_a), 32'd0);
        chk("t6_chan",    32'(chan_a), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p[0]  = 100;
        push(0, 100, 1'b0);
        check_next("t6_ch0");
        chk("t6_valid_after", 32'(val_a), 32'b0001);
        chk("t6_queue_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
